pred_update_sched: RTL and testbench

- Scheduler for the shared BTB/GShare update port of the fetch stage.
- Buffers predictor_update records arriving from commit in an in-order FIFO.
- Issues one update per cycle to the BTB write port and the GShare counter-update port, but only in cycles where fetch is not using the predictor arrays.
- A starvation counter forces an issue (and stalls fetch for one cycle) when updates are blocked for too long.

---
 rtl/pred_update_sched_pkg.sv | 31 +++
 rtl/pred_update_sched_fifo.sv | 46 ++++
 rtl/pred_update_sched.sv | 124 ++++++++++++
 tb/tb_pred_update_sched.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pred_update_sched_pkg.sv
// Shared types and defaults for the predictor update scheduler.
package pred_update_sched_pkg;

    localparam int UPD_PC_BITS    = 32;
    localparam int UPD_STARVE_MAX = 8;

    // Bit layout of the 72-bit commit record, MSB first.
    typedef struct packed {
        logic        valid_jump;
        logic        jump_taken;
        logic        is_comp;
        logic [1:0]  rat_id;
        logic [31:0] orig_pc;
        logic [31:0] jump_address;
        logic [2:0]  ticket;
    } predictor_update;

    typedef struct packed {
        logic        jump_taken;
        logic [31:0] orig_pc;
        logic [31:0] jump_address;
        logic [2:0]  ticket;
    } upd_entry_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FORCE = 2'd2
    } pred_upd_state_e;

endpackage

// File: rtl/pred_update_sched_fifo.sv
// Synchronous in-order FIFO; full/empty come from an extra pointer MSB.
module pred_upd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset: the head is only consumed while non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/pred_update_sched.sv
// Schedules committed predictor updates onto the shared BTB/GShare write port,
// stealing a fetch cycle only when updates have starved too long.
//
//   state   | meaning
//   S_IDLE  | FIFO empty, nothing to issue
//   S_WAIT  | head pending, issues whenever fetch leaves the arrays free
//   S_FORCE | head starved, issues unconditionally and stalls fetch if needed
module pred_update_sched
    import pred_update_sched_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = UPD_STARVE_MAX,
    parameter int PC_BITS    = UPD_PC_BITS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   upd_valid_i,
    input  logic [71:0]            upd_i,
    output logic                   upd_ready_o,
    input  logic                   fetch_rd_req_i,
    output logic                   fetch_stall_o,
    output logic                   btb_wr_en_o,
    output logic [PC_BITS-1:0]     btb_wr_pc_o,
    output logic [PC_BITS-1:0]     btb_wr_target_o,
    output logic                   gsh_upd_en_o,
    output logic [PC_BITS-1:0]     gsh_upd_pc_o,
    output logic                   gsh_upd_taken_o,
    output logic [2:0]             issued_ticket_o,
    output logic [$clog2(DEPTH):0] pending_o
);
    localparam int CW    = $clog2(STARVE_MAX + 1);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    predictor_update rec;
    upd_entry_t      push_entry;
    upd_entry_t      head;
    upd_entry_t      head_vis;
    logic            full;
    logic            empty;
    logic            push;
    logic            grant;
    logic [CNT_W-1:0] count;
    logic            unused_rec;

    pred_upd_state_e state_q, state_d;
    logic [CW-1:0]   starve_q, starve_d;

    assign rec         = upd_i;
    assign unused_rec  = ^{rec.is_comp, rec.rat_id};
    assign upd_ready_o = !full;
    // Records without a jump are accepted but never stored.
    assign push        = upd_valid_i && !full && rec.valid_jump;
    assign push_entry  = '{jump_taken:   rec.jump_taken,
                          orig_pc:      rec.orig_pc,
                          jump_address: rec.jump_address,
                          ticket:       rec.ticket};

    pred_upd_fifo #(
        .WIDTH ($bits(upd_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (grant),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (count)
    );

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        grant    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (push) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!fetch_rd_req_i) begin
                    grant    = 1'b1;
                    starve_d = '0;
                end else begin
                    if (starve_q < STARVE_LIM) starve_d = starve_q + CW'(1);
                    if (starve_d == STARVE_LIM) state_d = S_FORCE;
                end
            end
            S_FORCE: begin
                grant    = 1'b1;
                starve_d = '0;
            end
            default: begin
                state_d  = S_IDLE;
                starve_d = '0;
            end
        endcase
        if (grant) state_d = (count == CNT_W'(1) && !push) ? S_IDLE : S_WAIT;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    assign head_vis        = empty ? '0 : head;
    assign gsh_upd_en_o    = grant;
    assign btb_wr_en_o     = grant && head_vis.jump_taken;
    assign fetch_stall_o   = (state_q == S_FORCE) && fetch_rd_req_i;
    assign gsh_upd_pc_o    = PC_BITS'(head_vis.orig_pc);
    assign btb_wr_pc_o     = PC_BITS'(head_vis.orig_pc);
    assign btb_wr_target_o = PC_BITS'(head_vis.jump_address);
    assign gsh_upd_taken_o = head_vis.jump_taken;
    assign issued_ticket_o = head_vis.ticket;
    assign pending_o       = count;

endmodule

// File: tb/tb_pred_update_sched.sv
// Bench for pred_update_sched: directed table, hand sequences, random vs queue model.
module tb_pred_update_sched;
    localparam int DEPTH  = 4;
    localparam int STARVE = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        upd_valid_i = 1'b0;
    logic [71:0] upd_i = '0;
    logic        upd_ready_o;
    logic        fetch_rd_req_i = 1'b0;
    logic        fetch_stall_o;
    logic        btb_wr_en_o;
    logic [31:0] btb_wr_pc_o;
    logic [31:0] btb_wr_target_o;
    logic        gsh_upd_en_o;
    logic [31:0] gsh_upd_pc_o;
    logic        gsh_upd_taken_o;
    logic [2:0]  issued_ticket_o;
    logic [2:0]  pending_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pred_update_sched #(.DEPTH(DEPTH), .STARVE_MAX(STARVE), .PC_BITS(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .upd_valid_i     (upd_valid_i),
        .upd_i           (upd_i),
        .upd_ready_o     (upd_ready_o),
        .fetch_rd_req_i  (fetch_rd_req_i),
        .fetch_stall_o   (fetch_stall_o),
        .btb_wr_en_o     (btb_wr_en_o),
        .btb_wr_pc_o     (btb_wr_pc_o),
        .btb_wr_target_o (btb_wr_target_o),
        .gsh_upd_en_o    (gsh_upd_en_o),
        .gsh_upd_pc_o    (gsh_upd_pc_o),
        .gsh_upd_taken_o (gsh_upd_taken_o),
        .issued_ticket_o (issued_ticket_o),
        .pending_o       (pending_o)
    );

    typedef struct packed {
        logic        ready;
        logic [2:0]  pend;
        logic        gsh;
        logic        btb;
        logic        taken;
        logic        stall;
        logic [2:0]  tk;
        logic [31:0] pc;
        logic [31:0] tgt;
    } exp_t;

    typedef struct {
        logic        v;
        logic [71:0] rec;
        logic        fetch;
        exp_t        e;
    } vec_t;

    typedef struct packed {
        logic        taken;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic [2:0]  tk;
    } mrec_t;

    // Reference model: records waiting, consecutive blocked cycles, force pending.
    mrec_t m_q[$];
    int    m_blocked = 0;
    bit    m_force = 1'b0;

    function automatic logic [71:0] mk_rec(logic vj, logic taken, logic [31:0] pc,
                                           logic [31:0] tgt, logic [2:0] tk);
        return {vj, taken, 1'b0, 2'b00, pc, tgt, tk};
    endfunction

    function automatic exp_t mk_exp(logic rdy, int pend, logic gsh, logic btb, logic taken,
                                    logic stall, int tk, logic [31:0] pc, logic [31:0] tgt);
        exp_t e;
        e.ready = rdy;   e.pend = 3'(pend); e.gsh = gsh;  e.btb = btb;
        e.taken = taken; e.stall = stall;   e.tk = 3'(tk); e.pc = pc; e.tgt = tgt;
        return e;
    endfunction

    function automatic exp_t model_exp(logic fetch);
        exp_t e;
        bit   has;
        has     = m_q.size() > 0;
        e       = '0;
        e.ready = m_q.size() < DEPTH;
        e.pend  = 3'(m_q.size());
        e.gsh   = has && (m_force || !fetch);
        e.stall = m_force && fetch;
        if (has) begin
            e.btb   = e.gsh && m_q[0].taken;
            e.taken = m_q[0].taken;
            e.tk    = m_q[0].tk;
            e.pc    = m_q[0].pc;
            e.tgt   = m_q[0].tgt;
        end
        return e;
    endfunction

    function automatic void model_step(logic v, logic [71:0] r, logic fetch);
        bit has;
        bit rdy;
        bit issue;
        has   = m_q.size() > 0;
        rdy   = m_q.size() < DEPTH;
        issue = has && (m_force || !fetch);
        if (issue) begin
            void'(m_q.pop_front());
            m_blocked = 0;
            m_force   = 1'b0;
        end else if (has) begin
            m_blocked++;
            if (m_blocked >= STARVE) m_force = 1'b1;
        end
        if (v && rdy && r[71]) m_q.push_back('{r[70], r[66:35], r[34:3], r[2:0]});
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void check_outputs(string tag, exp_t e);
        chk({tag, ".ready"},  32'(upd_ready_o),     32'(e.ready));
        chk({tag, ".pend"},   32'(pending_o),       32'(e.pend));
        chk({tag, ".gsh_en"}, 32'(gsh_upd_en_o),    32'(e.gsh));
        chk({tag, ".btb_en"}, 32'(btb_wr_en_o),     32'(e.btb));
        chk({tag, ".taken"},  32'(gsh_upd_taken_o), 32'(e.taken));
        chk({tag, ".stall"},  32'(fetch_stall_o),   32'(e.stall));
        chk({tag, ".ticket"}, 32'(issued_ticket_o), 32'(e.tk));
        chk({tag, ".gsh_pc"}, gsh_upd_pc_o,         e.pc);
        chk({tag, ".btb_pc"}, btb_wr_pc_o,          e.pc);
        chk({tag, ".target"}, btb_wr_target_o,      e.tgt);
    endfunction

    task automatic run_cycle(input logic v, input logic [71:0] r, input logic fetch,
                             input exp_t e, input string tag);
        upd_valid_i    = v;
        upd_i          = r;
        fetch_rd_req_i = fetch;
        @(negedge clk);
        check_outputs(tag, e);
        model_step(v, r, fetch);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        upd_valid_i    = 1'b0;
        fetch_rd_req_i = 1'b1;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        m_q.delete();
        m_blocked = 0;
        m_force   = 1'b0;
    endtask

    vec_t        vecs[$];
    exp_t        zero_exp;
    logic [71:0] r;
    logic        v;
    logic        f;
    int          pct;
    int          pcts[4] = '{10, 50, 95, 100};

    initial begin
        zero_exp = mk_exp(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

        // Reset idle, taken branch, not-taken plus invalid record.
        vecs.push_back('{1'b0, 72'h0, 1'b0, zero_exp});
        vecs.push_back('{1'b1, mk_rec(1, 1, 32'h100, 32'h80, 3'd5), 1'b0, zero_exp});
        vecs.push_back('{1'b0, 72'h0, 1'b0, mk_exp(1, 1, 1, 1, 1, 0, 5, 32'h100, 32'h80)});
        vecs.push_back('{1'b0, 72'h0, 1'b0, zero_exp});
        vecs.push_back('{1'b1, mk_rec(1, 0, 32'h200, 32'h240, 3'd2), 1'b0, zero_exp});
        vecs.push_back('{1'b1, mk_rec(0, 1, 32'h300, 32'h340, 3'd3), 1'b0,
                         mk_exp(1, 1, 1, 0, 0, 0, 2, 32'h200, 32'h240)});
        vecs.push_back('{1'b0, 72'h0, 1'b0, zero_exp});
        vecs.push_back('{1'b0, 72'h0, 1'b0, zero_exp});
        // Fill to full while fetch blocks; fifth offer refused, then drain in order.
        for (int tk = 0; tk < 5; tk++)
            vecs.push_back('{1'b1, mk_rec(1, (tk % 2) == 0, 32'h1000 + 32'(16 * tk),
                                          32'h2000 + 32'(16 * tk), 3'(tk)), 1'b1,
                             (tk == 0) ? zero_exp
                                       : mk_exp(tk < 4, tk, 0, 0, 1, 0, 0, 32'h1000, 32'h2000)});
        for (int i = 0; i < 4; i++)
            vecs.push_back('{1'b0, 72'h0, 1'b0,
                             mk_exp((4 - i) < 4, 4 - i, 1, (i % 2) == 0, (i % 2) == 0, 0, i,
                                    32'h1000 + 32'(16 * i), 32'h2000 + 32'(16 * i))});
        vecs.push_back('{1'b0, 72'h0, 1'b0, zero_exp});

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vecs[i]) run_cycle(vecs[i].v, vecs[i].rec, vecs[i].fetch, vecs[i].e, "table");

        // Starvation twice in a row: the second round proves the counter restarted at 0.
        for (int rnd = 0; rnd < 2; rnd++) begin
            run_cycle(1'b1, mk_rec(1, 1, 32'h500, 32'h600, 3'(6 + rnd)), 1'b1, zero_exp, "starve_push");
            for (int k = 0; k < STARVE; k++)
                run_cycle(1'b0, 72'h0, 1'b1, mk_exp(1, 1, 0, 0, 1, 0, 6 + rnd, 32'h500, 32'h600),
                          "starve_blocked");
            run_cycle(1'b0, 72'h0, 1'b1, mk_exp(1, 1, 1, 1, 1, 1, 6 + rnd, 32'h500, 32'h600),
                      "starve_force");
            run_cycle(1'b0, 72'h0, 1'b1, zero_exp, "starve_after");
        end

        // Reset with three records pending discards them.
        for (int i = 0; i < 3; i++)
            run_cycle(1'b1, mk_rec(1, 1, 32'h700 + 32'(i), 32'h800, 3'(i)), 1'b1,
                      (i == 0) ? zero_exp : mk_exp(1, i, 0, 0, 1, 0, 0, 32'h700, 32'h800),
                      "rst_fill");
        run_cycle(1'b0, 72'h0, 1'b1, mk_exp(1, 3, 0, 0, 1, 0, 0, 32'h700, 32'h800), "rst_full3");
        do_reset();
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 72'h0, 1'b0, zero_exp, "rst_after");

        // Random traffic with varying fetch pressure against the queue model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            pct = pcts[(i / 50) % 4];
            v   = $urandom_range(99) < 70;
            r   = {$urandom_range(99) < 85, 1'($urandom), 1'($urandom), 2'($urandom),
                   32'($urandom), 32'($urandom), 3'($urandom)};
            f   = $urandom_range(99) < pct;
            if (i == 400) do_reset();
            run_cycle(v, r, f, model_exp(f), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
